// File: rtl/bg_rle_expander_pkg.sv
// Shared definitions for the background RLE expander: word layout,
// field widths, frame size and the controller state encoding.
package bg_rle_expander_pkg;

    localparam int BG_IDX_W        = 5;
    localparam int BG_RUN_W        = 11;
    localparam int BG_WORD_W       = 16;
    localparam int BG_TOTAL_PIXELS = 76800;
    localparam int BG_FIFO_DEPTH   = 2;

    // One ROM word: palette index in the top bits, run length minus one below.
    typedef struct packed {
        logic [BG_IDX_W-1:0] idx;
        logic [BG_RUN_W-1:0] run_m1;
    } bg_rle_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } bg_state_t;

    // Actual run length (1..2048) carried by a word.
    function automatic logic [BG_RUN_W:0] bg_run_len(input bg_rle_word_t w);
        return {1'b0, w.run_m1} + 1'b1;
    endfunction

endpackage

// File: rtl/bg_rle_expander_word_fifo.sv
// Two-entry word FIFO between the ROM and the run register. The count
// output is the fetch credit the controller uses to throttle ROM reads.
module bg_word_fifo
    import bg_rle_expander_pkg::*;
#(
    parameter int W = BG_WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [BG_FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Ignore pushes into a full FIFO and pops from an empty one.
    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bg_rle_expander.sv
// Background RLE expander: fetches run-length words from the background
// ROM and emits one palette index per pixel in raster order over a
// valid/ready stream, stopping after one frame's worth of pixels.
module bg_rle_expander
    import bg_rle_expander_pkg::*;
#(
    parameter int ROM_AW       = 14,
    parameter int TOTAL_PIXELS = BG_TOTAL_PIXELS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [BG_WORD_W-1:0] rom_data,
    output logic [BG_IDX_W-1:0]  pix_index,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int CNT_W = 17;
    // Pixels covered by captured words can overshoot the frame by one run.
    localparam int COV_W = $clog2(TOTAL_PIXELS + 4096);
    localparam logic [CNT_W-1:0]    LAST_PIX  = CNT_W'(TOTAL_PIXELS - 1);
    localparam logic [COV_W-1:0]    COV_LIMIT = COV_W'(TOTAL_PIXELS);
    localparam logic [BG_RUN_W:0]   RUN_ONE   = (BG_RUN_W+1)'(1);

    bg_state_t            state;
    bg_state_t            state_nxt;
    logic [CNT_W-1:0]     pix_cnt;
    logic [COV_W-1:0]     covered;
    logic                 rd_pend;
    logic [BG_RUN_W:0]    run_left;
    logic                 xfer;
    logic                 last_xfer;
    logic                 run_end;
    logic                 fetch_en;
    logic                 capture;
    logic                 load_en;
    logic                 fifo_flush;
    logic [1:0]           fifo_count;
    logic [BG_WORD_W-1:0] fifo_head;
    bg_rle_word_t         head_word;

    assign xfer      = pix_valid && pix_ready;
    assign last_xfer = xfer && (pix_cnt == LAST_PIX);
    assign run_end   = xfer && (run_left == RUN_ONE);
    assign head_word = bg_rle_word_t'(fifo_head);

    bg_word_fifo #(.W(BG_WORD_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (capture),
        .push_data (rom_data),
        .pop       (load_en),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a restart always wins, even over the final transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_FILL: if (fifo_count != 2'd0) state_nxt = ST_RUN;
            ST_RUN:  if (last_xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (frame_start) state_nxt = ST_FILL;
    end

    // Datapath controls. Reads are credited against FIFO room plus the one
    // outstanding read, and stop once captured words cover the frame.
    // A read issued before the last word was seen may still come back; it
    // is dropped rather than queued.
    always_comb begin
        fetch_en   = 1'b0;
        capture    = 1'b0;
        load_en    = 1'b0;
        fifo_flush = frame_start || last_xfer;
        if (state != ST_IDLE && !frame_start && !last_xfer) begin
            fetch_en = (({1'b0, fifo_count} + {2'b00, rd_pend}) < 3'd2) &&
                       (covered < COV_LIMIT);
            capture  = rd_pend && (covered < COV_LIMIT);
            load_en  = (!pix_valid || run_end) && (fifo_count != 2'd0);
        end
    end

    // ROM address, outstanding-read flag and frame coverage tally.
    // A restart issues the read of word 0 on the same edge and forgets any
    // read already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            rd_pend  <= 1'b0;
            covered  <= '0;
        end else if (frame_start) begin
            rom_addr <= '0;
            rd_pend  <= 1'b1;
            covered  <= '0;
        end else begin
            rd_pend <= fetch_en;
            if (fetch_en) rom_addr <= rom_addr + 1'b1;
            if (capture)  covered  <= covered + COV_W'(bg_run_len(bg_rle_word_t'(rom_data)));
        end
    end

    // Run register: present the current index, count down on transfers and
    // chain straight into the next FIFO word when a run finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
            run_left  <= '0;
        end else if (frame_start || last_xfer) begin
            pix_valid <= 1'b0;
        end else if (load_en) begin
            pix_valid <= 1'b1;
            pix_index <= head_word.idx;
            run_left  <= bg_run_len(head_word);
        end else if (run_end) begin
            pix_valid <= 1'b0;
        end else if (xfer) begin
            run_left <= run_left - 1'b1;
        end
    end

    // Pixel counter, busy flag and the end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (frame_start) begin
                pix_cnt <= '0;
                busy    <= 1'b1;
            end else if (last_xfer) begin
                pix_cnt <= '0;
                busy    <= 1'b0;
            end else if (xfer) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bg_rle_expander.sv
// Self-checking bench: a full-size instance for the 76800-pixel frame and
// a 64-pixel instance for randomized, truncation, restart and reset cases.
module tb_bg_rle_expander;
    import bg_rle_expander_pkg::*;

    localparam int AW    = 14;
    localparam int SMALL = 64;
    localparam int BIG   = BG_TOTAL_PIXELS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic b_start = 1'b0, b_ready = 1'b0;
    logic [AW-1:0] b_addr;
    logic [15:0]   b_data;
    logic [4:0]    b_idx;
    logic          b_valid, b_done, b_busy;

    logic s_start = 1'b0, s_ready = 1'b0;
    logic [AW-1:0] s_addr;
    logic [15:0]   s_data;
    logic [4:0]    s_idx;
    logic          s_valid, s_done, s_busy;

    logic [15:0] rom_b [0:(1<<AW)-1];
    logic [15:0] rom_s [0:(1<<AW)-1];
    assign b_data = rom_b[b_addr];
    assign s_data = rom_s[s_addr];

    bg_rle_expander #(.ROM_AW(AW), .TOTAL_PIXELS(BIG)) u_big (
        .clk(clk), .rst(rst), .frame_start(b_start), .rom_addr(b_addr),
        .rom_data(b_data), .pix_index(b_idx), .pix_valid(b_valid),
        .pix_ready(b_ready), .frame_done(b_done), .busy(b_busy));

    bg_rle_expander #(.ROM_AW(AW), .TOTAL_PIXELS(SMALL)) u_small (
        .clk(clk), .rst(rst), .frame_start(s_start), .rom_addr(s_addr),
        .rom_data(s_data), .pix_index(s_idx), .pix_valid(s_valid),
        .pix_ready(s_ready), .frame_done(s_done), .busy(s_busy));

    int checks = 0;
    int errors = 0;
    int got_q[$];
    int cyc_q[$];
    int exp_q[$];

    // Reference: expand words in order until the frame is full.
    task automatic build_model();
        logic [15:0] wd;
        exp_q.delete();
        for (int w = 0; w < (1 << AW) && exp_q.size() < SMALL; w++) begin
            wd = rom_s[w];
            for (int k = 0; k < int'(wd[10:0]) + 1 && exp_q.size() < SMALL; k++)
                exp_q.push_back(int'(wd[15:11]));
        end
    endtask

    task automatic fill_random_small(input int maxrun);
        for (int i = 0; i < (1 << AW); i++) rom_s[i] = 16'h0;
        for (int i = 0; i < 128; i++)
            rom_s[i] = {5'($urandom_range(0, 28)), 11'($urandom_range(0, maxrun - 1))};
    endtask

    task automatic pulse_start_s();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    // Drives pix_ready with the given duty, records transfers and stalls.
    task automatic drive_small(input int pct, input int maxc, output int lat,
                               output int dones, output int viol, output int done_cyc);
        logic pv, pr;
        logic [4:0] pi;
        got_q.delete(); cyc_q.delete();
        lat = -1; dones = 0; viol = 0; done_cyc = -1;
        pv = 1'b0; pr = 1'b0; pi = '0;
        for (int c = 0; c < maxc; c++) begin
            if (s_done && c > 0) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
            if (lat < 0 && s_valid) lat = c;
            if (pv && !pr && !(s_valid && s_idx == pi)) viol++;
            s_ready = ($urandom_range(0, 99) < pct);
            if (s_valid && s_ready) begin
                got_q.push_back(int'(s_idx));
                cyc_q.push_back(c);
            end
            pv = s_valid; pr = s_ready; pi = s_idx;
            @(posedge clk); #1;
        end
        s_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({b_addr, b_idx, b_valid, b_done, b_busy} !== '0) begin
            errors++; $display("FAIL reset_big got %h want 0", {b_addr, b_idx, b_valid, b_done, b_busy});
        end
        checks++;
        if ({s_addr, s_idx, s_valid, s_done, s_busy} !== '0) begin
            errors++; $display("FAIL reset_small got %h want 0", {s_addr, s_idx, s_valid, s_done, s_busy});
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset valid %b busy %b want 0 0", s_valid, s_busy);
        end
    endtask

    task automatic test_full_frame();
        int lat, n, bad, dones, tail;
        for (int i = 0; i < (1 << AW); i++) rom_b[i] = 16'h0;
        for (int i = 0; i < 38; i++) rom_b[i] = {5'd3, 11'd2047};
        rom_b[38] = {5'd3, 11'd1023};
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_addr !== '0) begin
            errors++; $display("FAIL big_start busy %b addr %0d want 1 0", b_busy, b_addr);
        end
        lat = -1; n = 0; bad = 0; dones = 0; tail = -1;
        b_ready = 1'b1;
        for (int c = 0; c < 80000; c++) begin
            if (b_done) begin dones++; if (tail < 0) tail = c; end
            if (tail >= 0 && c >= tail + 4) break;
            if (lat < 0 && b_valid) lat = c;
            if (b_valid) begin n++; if (b_idx !== 5'd3) bad++; end
            @(posedge clk); #1;
        end
        b_ready = 1'b0;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL big_latency got %0d want 2", lat); end
        checks++;
        if (n !== BIG) begin errors++; $display("FAIL big_count got %0d want %0d", n, BIG); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL big_index got %0d wrong want 0", bad); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL big_done got %0d pulses want 1", dones); end
        checks++;
        if (b_busy !== 1'b0) begin errors++; $display("FAIL big_busy got %b want 0", b_busy); end
    endtask

    task automatic test_short_runs();
        int lat, dones, viol, dc, nbad;
        fill_random_small(6);
        rom_s[0] = 16'h2801;
        rom_s[1] = 16'h0000;
        build_model();
        pulse_start_s();
        drive_small(100, 300, lat, dones, viol, dc);
        checks++;
        if (got_q.size() < 3 || got_q[0] !== 5 || got_q[1] !== 5 || got_q[2] !== 0) begin
            errors++; $display("FAIL short_head got size %0d want 5,5,0 first", got_q.size());
        end
        checks++;
        if (cyc_q.size() < 2 || cyc_q[1] !== cyc_q[0] + 1) begin
            errors++; $display("FAIL short_contig got non-adjacent 5,5 want adjacent");
        end
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL short_seq got %0d diffs want 0", nbad); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL short_latency got %0d want 2", lat); end
    endtask

    task automatic test_random_ready();
        int lat, dones, viol, dc, nbad;
        for (int it = 0; it < 3; it++) begin
            fill_random_small(8);
            build_model();
            pulse_start_s();
            drive_small(50, 2000, lat, dones, viol, dc);
            nbad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand_len it%0d got %0d want %0d", it, got_q.size(), exp_q.size());
            end
            checks++;
            if (nbad !== 0) begin errors++; $display("FAIL rand_seq it%0d got %0d diffs want 0", it, nbad); end
            checks++;
            if (viol !== 0) begin errors++; $display("FAIL rand_hold it%0d got %0d unstable want 0", it, viol); end
            checks++;
            if (dones !== 1) begin errors++; $display("FAIL rand_done it%0d got %0d want 1", it, dones); end
            checks++;
            if (cyc_q.size() == 0 || dc !== cyc_q[cyc_q.size()-1] + 1) begin
                errors++; $display("FAIL rand_done_cycle it%0d got %0d want last xfer + 1", it, dc);
            end
        end
    endtask

    task automatic test_truncate();
        int lat, dones, viol, dc, nbad;
        logic [AW-1:0] a0;
        logic moved, active;
        for (int i = 0; i < (1 << AW); i++) rom_s[i] = {5'd1, 11'd0};
        rom_s[0] = {5'd7, 11'd29};
        rom_s[1] = {5'd9, 11'd133};
        build_model();
        pulse_start_s();
        drive_small(100, 400, lat, dones, viol, dc);
        nbad = (got_q.size() == SMALL) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL trunc_seq got %0d diffs size %0d want 0 %0d", nbad, got_q.size(), SMALL); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL trunc_done got %0d want 1", dones); end
        a0 = s_addr; moved = 1'b0; active = 1'b0;
        s_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (s_addr !== a0) moved = 1'b1;
            if (s_valid || s_busy) active = 1'b1;
        end
        s_ready = 1'b0;
        checks++;
        if (moved !== 1'b0) begin errors++; $display("FAIL trunc_fetch got addr moved from %0d want stable", a0); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL trunc_idle got valid/busy high want 0"); end
    endtask

    task automatic test_restart_mid();
        int n, early, lat, dones, viol, dc, nbad;
        fill_random_small(4);
        build_model();
        pulse_start_s();
        n = 0; early = 0;
        s_ready = 1'b1;
        for (int c = 0; c < 500 && n < 30; c++) begin
            if (s_done) early++;
            if (s_valid) n++;
            @(posedge clk); #1;
        end
        s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        drive_small(100, 400, lat, dones, viol, dc);
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL restart_latency got %0d want 2", lat); end
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL restart_seq got %0d diffs want 0", nbad); end
        checks++;
        if (early !== 0 || dones !== 1) begin
            errors++; $display("FAIL restart_done got early %0d later %0d want 0 1", early, dones);
        end
    endtask

    task automatic test_restart_at_end();
        int n, lat, dones, viol, dc, nbad;
        fill_random_small(4);
        build_model();
        pulse_start_s();
        n = 0;
        s_ready = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (s_valid) begin
                if (n == SMALL - 1) break;
                n++;
            end
            @(posedge clk); #1;
        end
        s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b1) begin
            errors++; $display("FAIL end_restart done %b busy %b want 1 1", s_done, s_busy);
        end
        drive_small(100, 400, lat, dones, viol, dc);
        nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
        checks++;
        if (nbad !== 0 || dones !== 1) begin
            errors++; $display("FAIL end_restart_frame got %0d diffs %0d dones want 0 1", nbad, dones);
        end
    endtask

    task automatic test_mid_reset();
        fill_random_small(8);
        pulse_start_s();
        s_ready = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        checks++;
        if (s_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre busy %b want 1", s_busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_addr, s_idx, s_valid, s_done, s_busy} !== '0) begin
            errors++; $display("FAIL midrst_async got %h want 0", {s_addr, s_idx, s_valid, s_done, s_busy});
        end
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_addr !== '0) begin
            errors++; $display("FAIL midrst_quiet valid %b busy %b addr %0d want 0 0 0", s_valid, s_busy, s_addr);
        end
        s_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom_b[i] = 16'h0;
            rom_s[i] = 16'h0;
        end
        test_reset();
        test_full_frame();
        test_short_runs();
        test_random_ready();
        test_truncate();
        test_restart_mid();
        test_restart_at_end();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
